hdr_police_ctrl: RTL and testbench

HDR_POLICE_CTRL -- requirements
Module: hdr_police_ctrl

---
 rtl/hdr_police_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_hdr_police_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_police_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hdr_police_ctrl
//  Description : Streaming IPv4 header parser / policing controller.
//                Captures the 5-tuple fields from the first three 64-bit words
//                of a packet and presents them to an external combinational
//                classifier. It then issues a verdict over a valid/ready
//                channel and keeps saturating per-index hit counters plus one
//                miss counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdr_police_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  // packet stream
  input  logic [63:0]      s_data_i,
  input  logic             s_vld_i,
  input  logic             s_eop_i,
  output logic             s_rdy_o,
  // header fields towards the classifier
  output logic [31:0]      in_ip_o,
  output logic [31:0]      out_ip_o,
  output logic [7:0]       proto_o,
  output logic [15:0]      in_port_o,
  output logic [15:0]      out_port_o,
  // classifier result
  input  logic             match_i,
  input  logic [2:0]       index_i,
  // verdict channel
  output logic             v_vld_o,
  output logic             v_match_o,
  output logic [2:0]       v_index_o,
  output logic             v_inval_o,
  input  logic             v_rdy_i,
  // counter readout / clear
  input  logic [3:0]       cnt_sel_i,
  output logic [CNT_W-1:0] cnt_o,
  input  logic             clr_i
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR1    = 3'd1,
    ST_HDR2    = 3'd2,
    ST_CLASS   = 3'd3,
    ST_VERDICT = 3'd4,
    ST_DRAIN   = 3'd5
  } state_t;

  localparam logic [7:0]       VER_IHL5 = 8'h45;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // FSM and field registers
  state_t      state_q,    state_d;
  logic        rdy_q,      rdy_d;
  logic        inval_q,    inval_d;
  logic        eop_seen_q, eop_seen_d;
  logic [31:0] in_ip_q,    in_ip_d;
  logic [31:0] out_ip_q,   out_ip_d;
  logic [7:0]  proto_q,    proto_d;
  logic [15:0] in_port_q,  in_port_d;
  logic [15:0] out_port_q, out_port_d;
  logic        v_vld_q,    v_vld_d;
  logic        v_match_q,  v_match_d;
  logic [2:0]  v_index_q,  v_index_d;
  logic        v_inval_q,  v_inval_d;

  // counters
  logic [CNT_W-1:0] hit_q [8];
  logic [CNT_W-1:0] hit_d [8];
  logic [CNT_W-1:0] miss_q, miss_d;

  logic xfer;
  logic v_hs;

  assign xfer = s_vld_i & rdy_q;
  assign v_hs = v_vld_q & v_rdy_i;

  // Next-state and field-capture logic for the header parser
  always_comb begin
    state_d    = state_q;
    inval_d    = inval_q;
    eop_seen_d = eop_seen_q;
    in_ip_d    = in_ip_q;
    out_ip_d   = out_ip_q;
    proto_d    = proto_q;
    in_port_d  = in_port_q;
    out_port_d = out_port_q;
    v_vld_d    = v_vld_q;
    v_match_d  = v_match_q;
    v_index_d  = v_index_q;
    v_inval_d  = v_inval_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          // Only a plain 20-byte IPv4 header (version 4, IHL 5) is parsable.
          inval_d    = (s_data_i[63:56] != VER_IHL5);
          eop_seen_d = 1'b0;
          if (s_eop_i) begin
            inval_d    = 1'b1;
            eop_seen_d = 1'b1;
            state_d    = ST_CLASS;
          end else begin
            state_d    = ST_HDR1;
          end
        end
      end

      ST_HDR1: begin
        if (xfer) begin
          proto_d = s_data_i[55:48];
          in_ip_d = s_data_i[31:0];
          if (s_eop_i) begin
            inval_d    = 1'b1;
            eop_seen_d = 1'b1;
            state_d    = ST_CLASS;
          end else begin
            state_d    = ST_HDR2;
          end
        end
      end

      ST_HDR2: begin
        if (xfer) begin
          out_ip_d   = s_data_i[63:32];
          in_port_d  = s_data_i[31:16];
          out_port_d = s_data_i[15:0];
          eop_seen_d = s_eop_i;
          state_d    = ST_CLASS;
        end
      end

      ST_CLASS: begin
        // Classifier inputs have settled from the registered fields; sample once.
        v_vld_d   = 1'b1;
        v_match_d = inval_q ? 1'b0 : match_i;
        v_index_d = inval_q ? 3'd0 : index_i;
        v_inval_d = inval_q;
        state_d   = ST_VERDICT;
      end

      ST_VERDICT: begin
        if (v_rdy_i) begin
          v_vld_d = 1'b0;
          state_d = eop_seen_q ? ST_IDLE : ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (xfer && s_eop_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready is registered and follows the state being entered.
    rdy_d = (state_d == ST_IDLE) || (state_d == ST_HDR1) ||
            (state_d == ST_HDR2) || (state_d == ST_DRAIN);
  end

  // Parser state, captured header fields and registered verdict outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      inval_q    <= 1'b0;
      eop_seen_q <= 1'b0;
      in_ip_q    <= '0;
      out_ip_q   <= '0;
      proto_q    <= '0;
      in_port_q  <= '0;
      out_port_q <= '0;
      v_vld_q    <= 1'b0;
      v_match_q  <= 1'b0;
      v_index_q  <= '0;
      v_inval_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      inval_q    <= inval_d;
      eop_seen_q <= eop_seen_d;
      in_ip_q    <= in_ip_d;
      out_ip_q   <= out_ip_d;
      proto_q    <= proto_d;
      in_port_q  <= in_port_d;
      out_port_q <= out_port_d;
      v_vld_q    <= v_vld_d;
      v_match_q  <= v_match_d;
      v_index_q  <= v_index_d;
      v_inval_q  <= v_inval_d;
    end
  end

  // Counter update: clear wins, otherwise a saturating bump on each verdict handshake
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (clr_i) begin
      for (int i = 0; i < 8; i++) begin
        hit_d[i] = '0;
      end
      miss_d = '0;
    end else if (v_hs) begin
      if (v_match_q) begin
        if (hit_q[v_index_q] != CNT_MAX) begin
          hit_d[v_index_q] = hit_q[v_index_q] + CNT_ONE;
        end
      end else begin
        if (miss_q != CNT_MAX) begin
          miss_d = miss_q + CNT_ONE;
        end
      end
    end
  end

  // Hit and miss counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 8; i++) begin
        hit_q[i] <= '0;
      end
      miss_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        hit_q[i] <= hit_d[i];
      end
      miss_q <= miss_d;
    end
  end

  // Counter readout: 0-7 hit, 8 miss, anything above reads as zero
  always_comb begin
    cnt_o = '0;
    if (!cnt_sel_i[3]) begin
      cnt_o = hit_q[cnt_sel_i[2:0]];
    end else if (cnt_sel_i == 4'd8) begin
      cnt_o = miss_q;
    end
  end

  assign s_rdy_o    = rdy_q;
  assign in_ip_o    = in_ip_q;
  assign out_ip_o   = out_ip_q;
  assign proto_o    = proto_q;
  assign in_port_o  = in_port_q;
  assign out_port_o = out_port_q;
  assign v_vld_o    = v_vld_q;
  assign v_match_o  = v_match_q;
  assign v_index_o  = v_index_q;
  assign v_inval_o  = v_inval_q;

endmodule
`default_nettype wire

// File: tb/tb_hdr_police_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hdr_police_ctrl
//  Description : Directed self-checking bench for hdr_police_ctrl with a small
//                behavioural classifier attached to the header outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hdr_police_ctrl;

  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic [63:0]      s_data_i = '0;
  logic             s_vld_i = 1'b0;
  logic             s_eop_i = 1'b0;
  logic             s_rdy_o;
  logic [31:0]      in_ip_o;
  logic [31:0]      out_ip_o;
  logic [7:0]       proto_o;
  logic [15:0]      in_port_o;
  logic [15:0]      out_port_o;
  logic             match_i;
  logic [2:0]       index_i;
  logic             v_vld_o;
  logic             v_match_o;
  logic [2:0]       v_index_o;
  logic             v_inval_o;
  logic             v_rdy_i = 1'b0;
  logic [3:0]       cnt_sel_i = '0;
  logic [CNT_W-1:0] cnt_o;
  logic             clr_i = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  hdr_police_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .s_data_i   (s_data_i),
    .s_vld_i    (s_vld_i),
    .s_eop_i    (s_eop_i),
    .s_rdy_o    (s_rdy_o),
    .in_ip_o    (in_ip_o),
    .out_ip_o   (out_ip_o),
    .proto_o    (proto_o),
    .in_port_o  (in_port_o),
    .out_port_o (out_port_o),
    .match_i    (match_i),
    .index_i    (index_i),
    .v_vld_o    (v_vld_o),
    .v_match_o  (v_match_o),
    .v_index_o  (v_index_o),
    .v_inval_o  (v_inval_o),
    .v_rdy_i    (v_rdy_i),
    .cnt_sel_i  (cnt_sel_i),
    .cnt_o      (cnt_o),
    .clr_i      (clr_i)
  );

  always #5 clk_i = ~clk_i;

  // Classifier: two destination rules
  always_comb begin
    match_i = 1'b0;
    index_i = 3'd0;
    if (out_ip_o == 32'h0a010203) begin
      match_i = 1'b1;
      index_i = 3'd0;
    end else if (out_ip_o == 32'h0a030303) begin
      match_i = 1'b1;
      index_i = 3'd3;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic e);
    logic ok;
    ok = 1'b0;
    s_data_i = d;
    s_eop_i  = e;
    s_vld_i  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (s_rdy_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk_i);
      #1;
    end
    s_vld_i = 1'b0;
    s_eop_i = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_vld();
    for (int i = 0; i < 10; i++) begin
      if (v_vld_o) break;
      tick();
    end
    chk("vld_timeout", 64'(v_vld_o), 64'd1);
  endtask

  task automatic handshake(input logic clr);
    v_rdy_i = 1'b1;
    clr_i   = clr;
    tick();
    v_rdy_i = 1'b0;
    clr_i   = 1'b0;
  endtask

  task automatic rd_cnt(input string tag, input logic [3:0] sel, input logic [CNT_W-1:0] exp);
    cnt_sel_i = sel;
    #1;
    chk(tag, 64'(cnt_o), 64'(exp));
  endtask

  task automatic run_pkt(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2,
                         input logic em, input logic [2:0] ei, input logic einv);
    send(w0, 1'b0);
    send(w1, 1'b0);
    send(w2, 1'b1);
    wait_vld();
    chk("pkt_match", 64'(v_match_o), 64'(em));
    chk("pkt_index", 64'(v_index_o), 64'(ei));
    chk("pkt_inval", 64'(v_inval_o), 64'(einv));
    handshake(1'b0);
  endtask

  localparam logic [63:0] W0_OK  = 64'h4500_0028_0000_4000;
  localparam logic [63:0] W0_IHL = 64'h4600_002c_0000_4000;
  localparam logic [63:0] W1_TCP = {8'h40, 8'h06, 16'h0000, 32'h0a010003};
  localparam logic [63:0] W2_TCP = {32'h0a010203, 16'h0015, 16'h1234};
  localparam logic [63:0] W2_I3  = {32'h0a030303, 16'h0050, 16'h0051};

  initial begin
    // ---- reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rdy",    64'(s_rdy_o),  64'd0);
    chk("rst_vvld",   64'(v_vld_o),  64'd0);
    chk("rst_in_ip",  64'(in_ip_o),  64'd0);
    chk("rst_proto",  64'(proto_o),  64'd0);
    chk("rst_cnt",    64'(cnt_o),    64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("rdy_after_rst", 64'(s_rdy_o), 64'd1);

    // ---- 3-word TCP packet, field capture and two-cycle verdict latency
    send(W0_OK, 1'b0);
    send(W1_TCP, 1'b0);
    send(W2_TCP, 1'b1);
    chk("p1_in_ip",    64'(in_ip_o),    64'h0a010003);
    chk("p1_out_ip",   64'(out_ip_o),   64'h0a010203);
    chk("p1_proto",    64'(proto_o),    64'h06);
    chk("p1_in_port",  64'(in_port_o),  64'h0015);
    chk("p1_out_port", 64'(out_port_o), 64'h1234);
    chk("p1_vvld_early", 64'(v_vld_o),  64'd0);
    chk("p1_rdy_class",  64'(s_rdy_o),  64'd0);
    tick();
    chk("p1_vvld",  64'(v_vld_o),   64'd1);
    chk("p1_match", 64'(v_match_o), 64'd1);
    chk("p1_index", 64'(v_index_o), 64'd0);
    chk("p1_inval", 64'(v_inval_o), 64'd0);
    handshake(1'b0);
    chk("p1_vvld_clr", 64'(v_vld_o), 64'd0);
    chk("p1_rdy_idle", 64'(s_rdy_o), 64'd1);
    rd_cnt("p1_hit0", 4'd0, 4'd1);

    // ---- 5-word packet, mid-packet stall, back-pressured verdict, drain
    send(W0_OK, 1'b0);
    send({8'h40, 8'h11, 16'h0000, 32'h0a010004}, 1'b0);
    repeat (2) tick();
    chk("p2_rdy_stall", 64'(s_rdy_o), 64'd1);
    send({32'h0a0a0a0a, 16'h1000, 16'h2000}, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("p2_hold_vld",   64'(v_vld_o),   64'd1);
      chk("p2_hold_match", 64'(v_match_o), 64'd0);
      chk("p2_hold_rdy",   64'(s_rdy_o),   64'd0);
      tick();
    end
    handshake(1'b0);
    chk("p2_vvld_clr", 64'(v_vld_o), 64'd0);
    chk("p2_rdy_drain", 64'(s_rdy_o), 64'd1);
    send(64'h1111_2222_3333_4444, 1'b0);
    send(64'h5555_6666_7777_8888, 1'b1);
    chk("p2_rdy_idle", 64'(s_rdy_o), 64'd1);
    rd_cnt("p2_miss", 4'd8, 4'd1);

    // ---- IHL 6 header marks the packet invalid even if the rule matches
    run_pkt(W0_IHL, W1_TCP, W2_TCP, 1'b0, 3'd0, 1'b1);
    rd_cnt("p3_miss", 4'd8, 4'd2);
    rd_cnt("p3_hit0", 4'd0, 4'd1);

    // ---- eop on word 1: invalid verdict, no word-2 transfer, back to IDLE
    send(W0_OK, 1'b0);
    send({8'h40, 8'h06, 16'h0000, 32'h0a0b0c0d}, 1'b1);
    chk("p4_in_ip",   64'(in_ip_o),  64'h0a0b0c0d);
    chk("p4_out_hold", 64'(out_ip_o), 64'h0a010203);
    wait_vld();
    chk("p4_inval", 64'(v_inval_o), 64'd1);
    chk("p4_match", 64'(v_match_o), 64'd0);
    chk("p4_index", 64'(v_index_o), 64'd0);
    handshake(1'b0);
    chk("p4_rdy_idle", 64'(s_rdy_o), 64'd1);
    rd_cnt("p4_miss", 4'd8, 4'd3);
    rd_cnt("p4_sel9", 4'd9, 4'd0);
    run_pkt(W0_OK, W1_TCP, W2_TCP, 1'b1, 3'd0, 1'b0);
    rd_cnt("p4_hit0", 4'd0, 4'd2);

    // ---- saturation of hit[3] with a 4-bit counter
    for (int i = 0; i < 15; i++) begin
      run_pkt(W0_OK, W1_TCP, W2_I3, 1'b1, 3'd3, 1'b0);
    end
    rd_cnt("sat_hit3_full", 4'd3, 4'hF);
    for (int i = 0; i < 2; i++) begin
      run_pkt(W0_OK, W1_TCP, W2_I3, 1'b1, 3'd3, 1'b0);
    end
    rd_cnt("sat_hit3_hold", 4'd3, 4'hF);

    // ---- clear concurrent with a handshake wins
    send(W0_OK, 1'b0);
    send(W1_TCP, 1'b0);
    send(W2_I3, 1'b1);
    wait_vld();
    handshake(1'b1);
    rd_cnt("clr_hit3", 4'd3, 4'd0);
    rd_cnt("clr_hit0", 4'd0, 4'd0);
    rd_cnt("clr_miss", 4'd8, 4'd0);

    // ---- reset pulse while in HDR2
    run_pkt(W0_OK, W1_TCP, W2_TCP, 1'b1, 3'd0, 1'b0);
    send(W0_OK, 1'b0);
    send(W1_TCP, 1'b0);
    rst_ni = 1'b0;
    #1;
    chk("mrst_rdy",    64'(s_rdy_o),  64'd0);
    chk("mrst_in_ip",  64'(in_ip_o),  64'd0);
    chk("mrst_out_ip", 64'(out_ip_o), 64'd0);
    chk("mrst_proto",  64'(proto_o),  64'd0);
    chk("mrst_vvld",   64'(v_vld_o),  64'd0);
    rd_cnt("mrst_hit0", 4'd0, 4'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    run_pkt(W0_OK, W1_TCP, W2_TCP, 1'b1, 3'd0, 1'b0);
    chk("post_out_ip", 64'(out_ip_o), 64'h0a010203);
    rd_cnt("post_hit0", 4'd0, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
